// File: rtl/l4_isa_pkg.sv
// Shared ISA definitions for the L4 core: field widths, opcodes, packing.
// Used by the instruction loader and the instruction register decode.
package l4_isa_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned INSTR_W = OP_W + 3 * REG_W;

  localparam logic [OP_W-1:0] OP_NOP  = 4'hB;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, 12'h000};

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } instr_t;

  function automatic logic [INSTR_W-1:0] pack_instr(
    input logic [OP_W-1:0]  op,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2
  );
    instr_t w;
    w.op  = op;
    w.rd  = rd;
    w.rs1 = rs1;
    w.rs2 = rs2;
    return w;
  endfunction

endpackage

// File: rtl/l4_instr_loader.sv
// Streams instruction fields from upstream into instruction memory.
// Stops after a programmed word count or on a HALT opcode (written too).
module l4_instr_loader
  import l4_isa_pkg::*;
#(
  parameter int unsigned     ADDR_W  = 8,
  parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      opcode,
  input  logic [REG_W-1:0]     dest_reg,
  input  logic [REG_W-1:0]     src_reg1,
  input  logic [REG_W-1:0]     src_reg2,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [INSTR_W-1:0]   mem_data,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      words_written
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W:0]      remaining_q;
  logic [ADDR_W:0]      words_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [INSTR_W-1:0]   mem_data_q;
  logic                 mem_we_q;

  logic accept;
  logic last_word;

  assign in_ready  = (state_q == S_RUN);
  assign accept    = in_valid && in_ready;
  assign last_word = (remaining_q == LEN_ONE) || (opcode == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= NOP_WORD;
      mem_we_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q      <= base_addr;
            remaining_q <= length;
            words_q     <= '0;
            state_q     <= (length == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_data_q  <= pack_instr(opcode, dest_reg, src_reg1, src_reg2);
            addr_q      <= addr_q + 1'b1;
            remaining_q <= remaining_q - LEN_ONE;
            words_q     <= words_q + LEN_ONE;
            if (last_word) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign mem_we        = mem_we_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign words_written = words_q;

endmodule

// File: tb/tb_l4_instr_loader.sv
// Bench for l4_instr_loader: directed loads plus random loads checked
// against a word-list model of which words land at which addresses.
module tb_l4_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [3:0]  dest_reg;
  logic [3:0]  src_reg1;
  logic [3:0]  src_reg2;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic [8:0]  words_written;

  int nchk  = 0;
  int nfail = 0;

  logic [15:0] words [16];

  always #5 clk = ~clk;

  l4_instr_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .dest_reg      (dest_reg),
    .src_reg1      (src_reg1),
    .src_reg2      (src_reg2),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_we        (mem_we),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Words the model expects to be written: stop at length or first HALT.
  function automatic int exp_count(input int len);
    for (int i = 0; i < len; i++) begin
      if (words[i][15:12] == 4'hF) return i + 1;
    end
    return len;
  endfunction

  task automatic fill_words(input int halt_pct);
    for (int i = 0; i < 16; i++) begin
      words[i] = 16'($urandom);
      if ($urandom_range(99) < halt_pct) words[i][15:12] = 4'hF;
      else words[i][15:12] = 4'($urandom_range(14));
    end
  endtask

  task automatic run_load(input logic [7:0] base, input int len,
                          input int pct);
    int k;
    int nexp;
    int guard;
    logic pend;
    logic fin;
    logic [7:0] ea;
    logic [15:0] ed;
    nexp = exp_count(len);
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    length = 9'(len);
    k = 0; pend = 1'b0; fin = 1'b0; guard = 0;
    ea = '0; ed = '0;
    while (!fin && guard < 300) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      in_valid = 1'b0;
      chk("mem_we", 32'(mem_we), 32'(pend));
      if (pend) begin
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_data", 32'(mem_data), 32'(ed));
      end
      pend = 1'b0;
      if (done) begin
        fin = 1'b1;
        chk("count_at_done", 32'(k), 32'(nexp));
        chk("words_written", 32'(words_written), 32'(nexp));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
      end else begin
        chk("in_ready_run", 32'(in_ready), 32'd1);
        chk("busy_run", 32'(busy), 32'd1);
        if (k < nexp && $urandom_range(99) < pct) begin
          in_valid = 1'b1;
          {opcode, dest_reg, src_reg1, src_reg2} = words[k];
          ea = base + 8'(k);
          ed = words[k];
          pend = 1'b1;
          k++;
        end else begin
          {opcode, dest_reg, src_reg1, src_reg2} = 16'($urandom);
        end
        if ($urandom_range(3) == 0) begin
          start = 1'b1;
          base_addr = 8'($urandom);
          length = 9'($urandom);
        end
      end
    end
    if (!fin) chk("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("mem_we_after", 32'(mem_we), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd0);
    chk("words_hold", 32'(words_written), 32'(nexp));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    in_valid = 1'b0;
    {opcode, dest_reg, src_reg1, src_reg2} = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'hB000);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // Three-word load ending on a HALT that coincides with the count.
    fill_words(0);
    words[0] = 16'h1234;
    words[1] = 16'h5678;
    words[2] = 16'hF000;
    run_load(8'h10, 3, 100);

    // HALT in the second word cuts a five-word load short.
    fill_words(0);
    words[1][15:12] = 4'hF;
    run_load(8'h40, 5, 100);

    // Address wrap past the top of memory.
    fill_words(0);
    run_load(8'hFE, 3, 100);

    // Zero-length load.
    run_load(8'h33, 0, 100);

    // Sparse valids with start re-pulsed during the load.
    fill_words(0);
    run_load(8'h80, 2, 40);

    // in_valid in IDLE has no effect.
    @(negedge clk);
    in_valid = 1'b1;
    {opcode, dest_reg, src_reg1, src_reg2} = 16'h1111;
    repeat (2) begin
      @(negedge clk);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_words", 32'(words_written), 32'd2);
    end
    in_valid = 1'b0;

    for (int t = 0; t < 20; t++) begin
      fill_words(8);
      run_load(8'($urandom), int'($urandom_range(16)),
               int'($urandom_range(30, 100)));
    end

    // Reset lands on the edge of an accept mid-load.
    fill_words(0);
    @(negedge clk);
    start = 1'b1;
    base_addr = 8'h20;
    length = 9'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    {opcode, dest_reg, src_reg1, src_reg2} = words[0];
    @(negedge clk);
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    chk("pre_rst_data", 32'(mem_data), 32'(words[0]));
    {opcode, dest_reg, src_reg1, src_reg2} = words[1];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_data", 32'(mem_data), 32'hB000);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_words", 32'(words_written), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("post_rst_we", 32'(mem_we), 32'd0);

    fill_words(0);
    run_load(8'h70, 4, 70);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/l4_instr_loader.md
L4_INSTR_LOADER -- requirements
Module: l4_instr_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width.
REQ-002 The block SHALL have parameter HALT_OP, default 4'hF, meaning the opcode that terminates a load early.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a load, sampled only in IDLE.
REQ-006 The block SHALL have port base_addr  input  ADDR_W  first memory address written, latched on accepted start.
REQ-007 The block SHALL have port length  input  ADDR_W+1  number of words to write, latched on accepted start.
REQ-008 The block SHALL have port in_valid  input  1  upstream presents an instruction.
REQ-009 The block SHALL have port in_ready  output  1  loader accepts an instruction this cycle.
REQ-010 The block SHALL have ports opcode, dest_reg, src_reg1, src_reg2  input  4 each  instruction fields.
REQ-011 The block SHALL have port mem_addr  output  ADDR_W  write address.
REQ-012 The block SHALL have port mem_data  output  16  packed instruction word.
REQ-013 The block SHALL have port mem_we  output  1  one-cycle write strobe.
REQ-014 The block SHALL have port busy  output  1  high in RUN.
REQ-015 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 The block SHALL have port words_written  output  ADDR_W+1  count of words written in the current/last load.

Function
REQ-017 States SHALL be IDLE, RUN, DONE; in_ready SHALL equal (state==RUN), combinationally.
REQ-018 IDLE: on start=1 it SHALL latch base_addr into the address counter, length into remaining, clear words_written, and go to RUN; if length==0 it SHALL go to DONE instead.
REQ-019 An accept SHALL be in_valid && in_ready; on accept it SHALL register mem_data={opcode,dest_reg,src_reg1,src_reg2} (bits 15:12,11:8,7:4,3:0), mem_addr=current address, mem_we=1 on the next cycle (latency 1).
REQ-020 mem_we SHALL be 0 in every cycle not following an accept; mem_addr/mem_data SHALL hold their last values otherwise.
REQ-021 On accept the address counter SHALL increment modulo 2^ADDR_W (wrap 0xFF->0x00 at default), remaining SHALL decrement, words_written SHALL increment.
REQ-022 On accept with remaining==1 or opcode==HALT_OP it SHALL move to DONE at the same edge; the HALT word itself SHALL be written.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; words_written SHALL hold until the next accepted start.
REQ-024 start outside IDLE SHALL be ignored; in_valid outside RUN SHALL be ignored without side effects.
REQ-025 in_valid low in RUN SHALL stall indefinitely with no state change.

Reset
REQ-026 rst=1 at any edge, including mid-load, SHALL force IDLE, mem_we=0, done=0, busy=0, mem_addr=0, words_written=0, remaining=0, mem_data=16'hB000 (NOP encoding, opcode 11).
REQ-027 A write already registered SHALL be cancelled by reset (mem_we low in the cycle after the reset edge).

Structure
REQ-028 A shared package l4_isa_pkg SHALL hold field widths, opcode constants (NOP=4'hB, HALT=4'hF) and the field-packing function, shared with the instruction register decode.
REQ-029 No sub-module SHALL be used; the state type SHALL be local to the module.

Verification
REQ-030 start, base_addr=0x10, length=3, three back-to-back valids {1,2,3,4},{5,6,7,8},{F,0,0,0} -> writes 0x1234@0x10, 0x5678@0x11, 0xF000@0x12, done one cycle, words_written=3.
REQ-031 length=5, second word opcode=HALT -> two writes only, done after second accept, in_ready low thereafter.
REQ-032 base_addr=0xFE, length=3 -> addresses 0xFE, 0xFF, 0x00.
REQ-033 length=0 -> no mem_we, done pulses the cycle after start, in_ready never high.
REQ-034 rst asserted the cycle after an accept with length=4 -> no mem_we after reset edge, mem_data=0xB000, state IDLE, words_written=0.
REQ-035 in_valid toggling 1,0,0,1 with length=2 and start re-pulsed during RUN -> exactly two writes at consecutive addresses, second start ignored.
